// File: rtl/ntt_pkg.sv
// ntt_pkg: shared modulus, word type and modular add/sub helpers for the NTT datapath
package ntt_pkg;

    localparam int DATA_W = 28;

    typedef logic [DATA_W-1:0] word_t;

    // Q = 2^28 - 2^16 + 1
    localparam word_t Q = 28'd268369921;

    // The sum is formed one bit wider so a+b >= Q is detected without overflow
    function automatic word_t mod_add(input word_t a, input word_t b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= {1'b0, Q}) ? word_t'(s - {1'b0, Q}) : word_t'(s);
    endfunction

    // When a < b, a-b wraps mod 2^28; adding Q then lands back in [0, Q)
    function automatic word_t mod_sub(input word_t a, input word_t b);
        return (a >= b) ? a - b : a - b + Q;
    endfunction

endpackage

// File: rtl/modular_mult.sv
// modular_mult: out = a*b mod q, produced LAT cycles after the operands are presented
module modular_mult
    import ntt_pkg::*;
#(
    parameter int LAT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out
);

    logic [2*DATA_W-1:0] prod;
    word_t               red;
    word_t               pipe [LAT];

    assign prod = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign red  = word_t'(prod % (2*DATA_W)'(q));
    assign out  = pipe[LAT-1];

    // Reduced product enters the first stage and is carried LAT-1 more stages
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= red;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

endmodule

// File: rtl/inv_butterfly.sv
// inv_butterfly: streaming Gentleman-Sande butterfly mod Q with per-frame rotating twiddles.
// Optional macro INV_BUTTERFLY_HALVE_EN scales both outputs by 2^-1 mod Q in the output stage.
module inv_butterfly
    import ntt_pkg::*;
#(
    parameter int    START                = 0,
    parameter int    NUM_FACTORS          = 4,
    parameter word_t FACTORS [NUM_FACTORS] = '{default: word_t'(1)},
    parameter int    MULT_LAT             = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic              sync,
    output logic              out_valid,
    output logic [DATA_W-1:0] x_out,
    output logic [DATA_W-1:0] y_out
);

    localparam int SW = $clog2(START + 2);
    localparam int IW = (NUM_FACTORS > 1) ? $clog2(NUM_FACTORS) : 1;

    logic [SW-1:0]       k_cnt, k_cur;
    logic [IW-1:0]       idx, idx_cur, idx_nxt;
    logic                warm;
    word_t               w_sel;
    logic                v1, v2;
    word_t               x1, y1, w1, sum2, dif2, w2, prod, x_fin, y_fin;
    word_t               sum_pipe [MULT_LAT];
    logic [MULT_LAT-1:0] v_pipe;

    // A sync in this cycle makes the current sample k=0 of a new frame
    always_comb begin
        k_cur   = sync ? '0 : k_cnt;
        idx_cur = sync ? '0 : idx;
        warm    = k_cur != SW'(START);
        idx_nxt = (idx_cur == IW'(NUM_FACTORS - 1)) ? '0 : idx_cur + 1'b1;
        w_sel   = warm ? FACTORS[0] : FACTORS[idx_cur];
    end

    // Warm-up counter saturates at START, after which the table index rotates per accepted sample
    always_ff @(posedge clk) begin
        if (rst) begin
            k_cnt <= '0;
            idx   <= '0;
        end else begin
            k_cnt <= (in_valid && warm) ? k_cur + 1'b1 : k_cur;
            idx   <= (in_valid && !warm) ? idx_nxt : idx_cur;
        end
    end

    // Input capture, sum/difference, and sum delay matched to the multiplier latency
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            v_pipe <= '0;
        end else begin
            v1     <= in_valid;
            v2     <= v1;
            v_pipe <= MULT_LAT'({v_pipe, v2});
        end
        x1          <= x_in;
        y1          <= y_in;
        w1          <= w_sel;
        sum2        <= mod_add(x1, y1);
        dif2        <= mod_sub(x1, y1);
        w2          <= w1;
        sum_pipe[0] <= sum2;
        for (int i = 1; i < MULT_LAT; i++) sum_pipe[i] <= sum_pipe[i-1];
    end

    modular_mult #(.LAT(MULT_LAT)) u_mult (
        .a   (dif2),
        .b   (w2),
        .q   (Q),
        .clk (clk),
        .rst (rst),
        .out (prod)
    );

`ifdef INV_BUTTERFLY_HALVE_EN
    function automatic word_t halve(input word_t v);
        return v[0] ? word_t'(({1'b0, v} + {1'b0, Q}) >> 1) : v >> 1;
    endfunction

    // Multiply both results by the inverse of 2 before registering them
    always_comb begin
        x_fin = halve(sum_pipe[MULT_LAT-1]);
        y_fin = halve(prod);
    end
`else
    // Results pass to the output stage unscaled
    always_comb begin
        x_fin = sum_pipe[MULT_LAT-1];
        y_fin = prod;
    end
`endif

    // Output stage updates only on valid results and holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            out_valid <= v_pipe[MULT_LAT-1];
            if (v_pipe[MULT_LAT-1]) begin
                x_out <= x_fin;
                y_out <= y_fin;
            end
        end
    end

endmodule

// File: doc/inv_butterfly.md
INV_BUTTERFLY -- requirements
Module: inv_butterfly

Interface
REQ-001 SHALL have parameter START, default 0: the number of accepted samples per frame that use twiddle index 0 before the index begins rotating.
REQ-002 SHALL have parameter NUM_FACTORS, default 4: the twiddle table depth, which is a power of two between 1 and 64.
REQ-003 SHALL have parameter FACTORS[NUM_FACTORS], default all 1: the inverse twiddle table, with each entry a 28-bit value less than Q.
REQ-004 SHALL have parameter MULT_LAT, default 5: the latency of the modular multiplier in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1 bit: marks the current x_in/y_in pair as a sample.
REQ-008 SHALL have port x_in, input, 28 bits: even operand, less than Q.
REQ-009 SHALL have port y_in, input, 28 bits: odd operand, less than Q.
REQ-010 SHALL have port sync, input, 1 bit: frame-start pulse.
REQ-011 SHALL have port out_valid, output, 1 bit: marks the current x_out/y_out pair as a result.
REQ-012 SHALL have port x_out, output, 28 bits: the sum output.
REQ-013 SHALL have port y_out, output, 28 bits: the twiddled difference output.

Function
REQ-014 SHALL operate modulo Q = 2^28 - 2^16 + 1 = 268369921 and produce every output value in [0, Q).
REQ-015 SHALL be a Gentleman-Sande butterfly: x_out = (x + y) mod Q and y_out = ((x - y) mod Q) * w mod Q.
REQ-016 SHALL compute mod-add as: if a+b >= Q, then a+b-Q, else a+b; the sum is evaluated 29 bits wide.
REQ-017 SHALL compute mod-sub as: if a >= b, then a-b, else a-b+Q.
REQ-018 SHALL use this pipeline: cycle 1 registers the inputs; cycle 2 registers the sum and difference; the difference then passes through modular_mult (MULT_LAT cycles) while the sum is delayed MULT_LAT cycles to match; the final cycle registers the outputs.
REQ-019 SHALL have a fixed latency L = MULT_LAT+3 cycles (8 by default) from an accepted input to the matching out_valid.
REQ-020 SHALL be streaming only, with no backpressure: an input is accepted every cycle that in_valid=1.
REQ-021 SHALL pipe out_valid as in_valid delayed L cycles, and SHALL hold x_out/y_out at their last values while out_valid=0.
REQ-022 SHALL select the twiddle for the k-th accepted sample of a frame (counting from 0) as index 0 when k < START, else (k-START) mod NUM_FACTORS.
REQ-023 SHALL latch the twiddle at acceptance and pipe it alongside the sample; cycles with in_valid=0 SHALL NOT advance k.
REQ-024 SHALL saturate the START counter once it reaches START, and SHALL wrap the index from NUM_FACTORS-1 to 0.
REQ-025 SHALL clear k to 0 on sync=1; when sync and in_valid are high together, that sample SHALL be k=0 of the new frame.
REQ-026 SHALL let samples already in flight when sync arrives complete with the twiddles they already hold.

Reset
REQ-027 SHALL, on rst=1 at a clock edge, clear all valid pipeline stages, x_out, y_out, k and the index to 0.
REQ-028 SHALL, when reset is applied mid-stream, discard all in-flight samples so that no stale out_valid appears after reset.
REQ-029 SHALL give rst priority over sync and in_valid in the same cycle.

Configuration
REQ-030 SHALL provide macro INV_BUTTERFLY_HALVE_EN.
REQ-031 SHALL, when INV_BUTTERFLY_HALVE_EN is defined, multiply both outputs by 2^-1 mod Q in the output stage (v even: v>>1; v odd: (v+Q)>>1), with latency unchanged.
REQ-032 SHALL, when INV_BUTTERFLY_HALVE_EN is undefined, output unscaled results and contain no halving logic.

Structure
REQ-033 SHALL take the following from the shared package ntt_pkg: constant Q, constant DATA_W=28, typedef word_t, and the mod-add/mod-sub functions.
REQ-034 SHALL instantiate exactly one sub-module, modular_mult (a, b, q, clk, rst, out), with latency MULT_LAT.

Verification
REQ-035 SHALL pass the basic case: after reset, x=5, y=3, FACTORS all 1 -> 8 cycles later out_valid=1, x_out=8, y_out=2 (x_out=4, y_out=1 with HALVE_EN).
REQ-036 SHALL pass underflow: x=3, y=5, w=1 -> y_out=268369919 (268369920 with HALVE_EN).
REQ-037 SHALL pass overflow wrap: x=268369920, y=2 -> x_out=1 (134184961 with HALVE_EN).
REQ-038 SHALL pass twiddle rotation: FACTORS={1,2,3,4}, START=2, six samples x=0, y=1 with one idle cycle inserted -> y_out = Q-1, Q-1, Q-1, Q-2, Q-3, Q-4 (unscaled); then sync with valid -> the next sample uses w=1.
REQ-039 SHALL pass mid-stream reset: rst pulsed for 1 cycle while 4 samples are in flight -> out_valid=0 for the following 8 cycles, x_out=y_out=0.
